// File: rtl/airi5c_spi_fifo.sv
// First-word-fall-through FIFO between the SPI register interface and the shift engine.
// Provides level, watermark and sticky overflow/underflow flags for status and interrupts.
module airi5c_spi_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  flush,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic [ADDR_WIDTH:0]   threshold,
    output logic                  thr_reached,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0]   LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LVL_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_loaded;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [ADDR_WIDTH:0]   w_level_nxt;

    // Strobe acceptance, error events and next level; flush masks every strobe.
    always_comb begin
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        w_ovf_evt   = 1'b0;
        w_udf_evt   = 1'b0;
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = LVL_ZERO;
        end else begin
            w_wr_acc  = we && (!full || re);
            w_rd_acc  = re && !empty;
            w_ovf_evt = we && full && !re;
            w_udf_evt = re && empty;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_level_nxt = r_level + LVL_ONE;
                2'b01:   w_level_nxt = r_level - LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers and level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_level <= LVL_ZERO;
        end else if (flush) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_level <= LVL_ZERO;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
        end
    end

    // Sticky error flags: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt || (r_ovf && !clr_err);
            r_udf <= w_udf_evt || (r_udf && !clr_err);
        end
    end

    // Forces rdata to zero until the first entry lands in the uninitialised array.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_loaded <= 1'b0;
        end else if (w_wr_acc) begin
            r_loaded <= 1'b1;
        end else begin
            r_loaded <= r_loaded;
        end
    end

    assign rdata       = r_loaded ? r_mem[r_rptr] : {DATA_WIDTH{1'b0}};
    assign level       = r_level;
    assign full        = (r_level == LVL_FULL);
    assign empty       = (r_level == LVL_ZERO);
    assign thr_reached = (r_level >= threshold);
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

endmodule

// File: tb/tb_airi5c_spi_fifo.sv
// Self-checking bench for airi5c_spi_fifo: vector table for flags/level, scoreboard queue for data.
module tb_airi5c_spi_fifo;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       flush = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       re = 1'b0;
    logic [7:0] rdata;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic [3:0] threshold = 4'd0;
    logic       thr_reached;
    logic       overflow;
    logic       underflow;
    logic       clr_err = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       fl;
        logic       clr;
        logic [3:0] thr;
        logic [3:0] e_level;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_udf;
        logic       e_thr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    airi5c_spi_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .n_reset(n_reset), .flush(flush), .we(we), .wdata(wdata),
        .re(re), .rdata(rdata), .full(full), .empty(empty), .level(level),
        .threshold(threshold), .thr_reached(thr_reached), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic [7:0] d, input logic r,
                                input logic f, input logic c, input logic [3:0] t,
                                input int lv, input logic fu, input logic em,
                                input logic ov, input logic ud, input logic th);
        vec_t v;
        v.we = w; v.wd = d; v.re = r; v.fl = f; v.clr = c; v.thr = t;
        v.e_level = lv[3:0]; v.e_full = fu; v.e_empty = em;
        v.e_ovf = ov; v.e_udf = ud; v.e_thr = th;
        vecs.push_back(v);
    endfunction

    function automatic void add_fill8(input logic ov);
        for (int i = 0; i < 8; i++)
            add(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0, 1'b0, 4'd4,
                i + 1, i == 7, 1'b0, ov, 1'b0, (i + 1) >= 4);
    endfunction

    function automatic void add_drain8(input logic ov);
        for (int i = 0; i < 8; i++)
            add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4,
                7 - i, 1'b0, i == 7, ov, 1'b0, (7 - i) >= 4);
    endfunction

    // Drive one vector, check popped data before the edge, check flags after it.
    task automatic apply(input vec_t v, input int idx);
        logic w_acc;
        we = v.we; wdata = v.wd; re = v.re; flush = v.fl; clr_err = v.clr; threshold = v.thr;
        @(negedge clk);
        w_acc = !v.fl && v.we && (sb.size() < 8 || v.re);
        if (v.fl) begin
            sb.delete();
        end else if (v.re && sb.size() > 0) begin
            chk($sformatf("rdata[%0d]", idx), int'(rdata), int'(sb[0]));
            void'(sb.pop_front());
        end
        if (w_acc) sb.push_back(v.wd);
        @(posedge clk);
        #1;
        chk($sformatf("level[%0d]", idx), int'(level), int'(v.e_level));
        chk($sformatf("full[%0d]", idx), int'(full), int'(v.e_full));
        chk($sformatf("empty[%0d]", idx), int'(empty), int'(v.e_empty));
        chk($sformatf("overflow[%0d]", idx), int'(overflow), int'(v.e_ovf));
        chk($sformatf("underflow[%0d]", idx), int'(underflow), int'(v.e_udf));
        chk($sformatf("thr[%0d]", idx), int'(thr_reached), int'(v.e_thr));
    endtask

    initial begin
        // Fill then drain: data order and full/empty boundaries.
        add_fill8(1'b0);
        add_drain8(1'b0);
        // Overflow on the ninth write, data intact, then clear.
        add_fill8(1'b0);
        add(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 4'd4, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add_drain8(1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Threshold above depth, then simultaneous write+read while full (pointer wrap).
        add_fill8(1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 4'd4, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_drain8(1'b0);
        // Empty with write+read and clear in the same cycle: underflow wins.
        add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 4'd4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Underflow, four writes to the watermark, then flush with a write.
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 4'd4,
                i + 1, 1'b0, 1'b0, 1'b0, 1'b1, (i + 1) >= 4);
        add(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 4'd4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 4'd4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset state, including the zero-threshold and rdata-zero corner.
        #12;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_thr0", int'(thr_reached), 1);
        threshold = 4'd5;
        #1;
        chk("rst_thr5", int'(thr_reached), 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rdata", int'(rdata), 0);
        chk("idle_empty", int'(empty), 1);

        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

        we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
